// File: rtl/median_stream_filter_pkg.sv
// Shared constants and FSM encoding for the streaming 5-tap median filter.
package median_stream_filter_pkg;

  localparam int unsigned DATA_W_DEF = 4;
  localparam int unsigned WIN_DEPTH  = 5;
  localparam int unsigned CNT_W      = 3;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/median_stream_filter_median5_net.sv
// Combinational rank-3 selector over five unsigned inputs (compare-exchange network).
module median5_net #(
  parameter int unsigned DATA_W = 4
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  input  logic [DATA_W-1:0] d,
  input  logic [DATA_W-1:0] e,
  output logic [DATA_W-1:0] median_c
);

  logic [DATA_W-1:0] lo0, hi0, lo1, hi1;
  logic [DATA_W-1:0] keep_lo, keep_hi;
  logic [DATA_W-1:0] m3_lo, m3_hi, m3_mid;

  // Sort the two pairs.
  assign lo0 = (a < b) ? a : b;
  assign hi0 = (a < b) ? b : a;
  assign lo1 = (c < d) ? c : d;
  assign hi1 = (c < d) ? d : c;

  // The smaller low and the larger high can never be the median; keep the others.
  assign keep_lo = (lo0 < lo1) ? lo1 : lo0;
  assign keep_hi = (hi0 > hi1) ? hi1 : hi0;

  // Median of the remaining three values.
  assign m3_lo    = (keep_lo < keep_hi) ? keep_lo : keep_hi;
  assign m3_hi    = (keep_lo < keep_hi) ? keep_hi : keep_lo;
  assign m3_mid   = (m3_hi < e) ? m3_hi : e;
  assign median_c = (m3_lo > m3_mid) ? m3_lo : m3_mid;

endmodule

// File: rtl/median_stream_filter.sv
// Streaming 5-tap sliding-window median filter with valid/ready flow control.
module median_stream_filter
  import median_stream_filter_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned WIN    = WIN_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              win_full
);

  generate
    if (WIN != 5) begin : g_bad_win
      $error("median_stream_filter supports WIN == 5 only");
    end
  endgenerate

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              accept_c;
  logic              produce_c;
  logic [DATA_W-1:0] median_c;
  // Oldest sample (w4) never feeds the median of the post-shift window, so only w0..w3 are kept.
  logic [DATA_W-1:0] win_q [4];

  assign in_ready = !clear && (!out_valid || out_ready);
  assign accept_c = in_valid && in_ready;
  assign win_full = (state_q == ST_RUN);

  median5_net #(.DATA_W(DATA_W)) u_median5 (
    .a        (in_data),
    .b        (win_q[0]),
    .c        (win_q[1]),
    .d        (win_q[2]),
    .e        (win_q[3]),
    .median_c (median_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FILL;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Fill counting and the decision whether this accept produces a median.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    produce_c = 1'b0;
    if (clear) begin
      state_d = ST_FILL;
      count_d = '0;
    end else begin
      case (state_q)
        ST_FILL: begin
          if (accept_c) begin
            count_d = count_q + CNT_W'(1);
            if (count_q == CNT_W'(WIN_DEPTH - 1)) begin
              state_d   = ST_RUN;
              produce_c = 1'b1;
            end
          end
        end
        ST_RUN: begin
          produce_c = accept_c;
        end
        default: begin
          state_d = ST_FILL;
          count_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) win_q[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < 4; i++) win_q[i] <= '0;
    end else if (accept_c) begin
      win_q[3] <= win_q[2];
      win_q[2] <= win_q[1];
      win_q[1] <= win_q[0];
      win_q[0] <= in_data;
    end
  end

  // Output register: a new median wins over a simultaneous consume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (clear) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (produce_c) begin
      out_valid <= 1'b1;
      out_data  <= median_c;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_median_stream_filter.sv
// Directed self-checking bench for median_stream_filter.
module tb_median_stream_filter;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [3:0] out_data;
  logic       out_ready;
  logic       win_full;

  int total;
  int bad;

  median_stream_filter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .win_full  (win_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one sample and hold it until accepted, then advance past that edge.
  task automatic push(input logic [3:0] d);
    int waited;
    in_valid = 1'b1;
    in_data  = d;
    #1;
    waited = 0;
    while (!in_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("push_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_fill(input string tag);
    logic [3:0] seq [5];
    seq[0] = 4'd3; seq[1] = 4'd9; seq[2] = 4'd1; seq[3] = 4'd7; seq[4] = 4'd5;
    for (int i = 0; i < 4; i++) begin
      push(seq[i]);
      chk({tag, "_fill_valid"}, int'(out_valid), 0);
      chk({tag, "_fill_full"},  int'(win_full), 0);
    end
    push(seq[4]);
    chk({tag, "_first_valid"}, int'(out_valid), 1);
    chk({tag, "_first_data"},  int'(out_data), 5);
    chk({tag, "_first_full"},  int'(win_full), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] s4 [5];
    logic [3:0] s15 [5];
    logic [3:0] salt [5];
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    clear = 1'b0;
    in_valid = 1'b0;
    in_data = 4'd0;
    out_ready = 1'b1;

    #12;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data",  int'(out_data), 0);
    chk("rst_win_full",  int'(win_full), 0);
    chk("rst_in_ready",  int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fill and slide.
    run_fill("t1");
    push(4'd15);
    chk("slide1_data", int'(out_data), 7);
    push(4'd0);
    chk("slide2_data", int'(out_data), 5);

    // Backpressure: window is 0,15,5,7,1 with median 5 pending.
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 4'd9;
    #1;
    chk("bp_in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    chk("bp_frozen_valid", int'(out_valid), 1);
    chk("bp_frozen_data",  int'(out_data), 5);
    chk("bp_still_stall",  int'(in_ready), 0);
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_new_valid", int'(out_valid), 1);
    chk("bp_new_data",  int'(out_data), 7);
    @(posedge clk); #1;
    chk("bp_consumed_valid", int'(out_valid), 0);
    chk("bp_hold_data",      int'(out_data), 7);
    push(4'd1);
    chk("bp_no_dup_data", int'(out_data), 5);

    // Duplicates and extremes.
    s4[0] = 4'd4;  s4[1] = 4'd4;  s4[2] = 4'd4;  s4[3] = 4'd0;  s4[4] = 4'd15;
    s15[0] = 4'd15; s15[1] = 4'd15; s15[2] = 4'd15; s15[3] = 4'd15; s15[4] = 4'd15;
    salt[0] = 4'd0; salt[1] = 4'd15; salt[2] = 4'd0; salt[3] = 4'd15; salt[4] = 4'd0;
    for (int i = 0; i < 5; i++) push(s4[i]);
    chk("dup_4", int'(out_data), 4);
    for (int i = 0; i < 5; i++) push(s15[i]);
    chk("dup_15", int'(out_data), 15);
    for (int i = 0; i < 5; i++) push(salt[i]);
    chk("alt_0", int'(out_data), 0);
    chk("alt_valid", int'(out_valid), 1);

    // Clear with a pending median.
    clear = 1'b1;
    in_valid = 1'b1;
    in_data = 4'd8;
    #1;
    chk("clr_in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    clear = 1'b0;
    in_valid = 1'b0;
    chk("clr_out_valid", int'(out_valid), 0);
    chk("clr_win_full",  int'(win_full), 0);
    push(4'd6);
    chk("clr_refill1", int'(out_valid), 0);
    push(4'd1);
    push(4'd8);
    push(4'd3);
    chk("clr_refill4", int'(out_valid), 0);
    chk("clr_refill4_full", int'(win_full), 0);
    push(4'd2);
    chk("clr_first_valid", int'(out_valid), 1);
    chk("clr_first_data",  int'(out_data), 3);

    // Async reset between edges while running.
    push(4'd10);
    chk("pre_rst_data", int'(out_data), 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_out_data",  int'(out_data), 0);
    chk("arst_win_full",  int'(win_full), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_fill("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
